// File: rtl/multichannel_delay_line.sv
// rtl/multichannel_delay_line.sv - N-channel audio delay line over one shared synchronous-read RAM
// Optional macro MULTICHANNEL_DELAY_FEEDBACK_EN stores input + (delayed>>>1), saturated, for a decaying echo.
module multichannel_delay_line #(
  parameter int NUM_CHANNELS = 3,
  parameter int SAMPLE_WIDTH = 16,
  parameter int MAX_DELAY    = 4096,
  parameter int DELAY_WIDTH  = $clog2(MAX_DELAY)
) (
  input  logic                                 audio_clk,
  input  logic                                 rst_in,
  input  logic                                 sample_valid_in,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] sample_in,
  input  logic [NUM_CHANNELS*DELAY_WIDTH-1:0]  delay_in,
  output logic                                 sample_valid_out,
  output logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] sample_out,
  output logic                                 busy,
  output logic                                 overrun
);

  localparam int CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int STEP_W = $clog2(NUM_CHANNELS + 1);
  localparam int ADDR_W = CH_W + DELAY_WIDTH;
  localparam int DEPTH  = NUM_CHANNELS * MAX_DELAY;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_CHANNELS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_next;

  logic [STEP_W-1:0]      step;
  logic [DELAY_WIDTH-1:0] wr_ptr;
  logic [DELAY_WIDTH-1:0] fill;

  logic [NUM_CHANNELS-1:0][SAMPLE_WIDTH-1:0] in_frame;
  logic [NUM_CHANNELS-1:0][DELAY_WIDTH-1:0]  delay_frame;
  logic [NUM_CHANNELS-1:0][SAMPLE_WIDTH-1:0] out_stage;
  logic [NUM_CHANNELS-1:0][SAMPLE_WIDTH-1:0] out_stage_next;
  logic [NUM_CHANNELS-1:0][SAMPLE_WIDTH-1:0] out_reg;

  logic [SAMPLE_WIDTH-1:0] mem [DEPTH];
  logic [SAMPLE_WIDTH-1:0] rd_data;
  logic [SAMPLE_WIDTH-1:0] wr_data;
  logic [ADDR_W-1:0]       rd_addr;
  logic [ADDR_W-1:0]       wr_addr;
  logic                    rd_en;
  logic                    wr_en;

  logic [CH_W-1:0]         rd_idx;
  logic [CH_W-1:0]         wr_idx;
  logic [DELAY_WIDTH-1:0]  rd_ptr;
  logic [DELAY_WIDTH-1:0]  cur_delay;
  logic [SAMPLE_WIDTH-1:0] cur_sample;
  logic [SAMPLE_WIDTH-1:0] sel_sample;
  logic                    warm_up;

`ifdef MULTICHANNEL_DELAY_FEEDBACK_EN
  logic signed [SAMPLE_WIDTH-1:0] fb_term;
  logic signed [SAMPLE_WIDTH:0]   fb_sum;
`endif

  assign sample_out = out_reg;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sample_valid_in) state_next = RUN;
      RUN:     if (step == LAST_STEP) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Step s reads channel s and retires channel s-1, whose read was issued last cycle.
  always_comb begin
    rd_en      = (state == RUN) && (step < LAST_STEP);
    wr_en      = (state == RUN) && (step != '0);
    rd_idx     = (step < LAST_STEP) ? CH_W'(step) : '0;
    wr_idx     = (step != '0) ? CH_W'(step - 1'b1) : '0;
    rd_ptr     = wr_ptr - delay_frame[rd_idx];
    rd_addr    = {rd_idx, rd_ptr};
    wr_addr    = {wr_idx, wr_ptr};
    cur_delay  = delay_frame[wr_idx];
    cur_sample = in_frame[wr_idx];
    warm_up    = cur_delay > fill;

    if (cur_delay == '0) begin
      sel_sample = cur_sample;
    end else if (warm_up) begin
      sel_sample = '0;
    end else begin
      sel_sample = rd_data;
    end

    out_stage_next = out_stage;
    if (wr_en) out_stage_next[wr_idx] = sel_sample;

`ifdef MULTICHANNEL_DELAY_FEEDBACK_EN
    fb_term = ((cur_delay == '0) || warm_up) ? '0 : ($signed(rd_data) >>> 1);
    fb_sum  = $signed({cur_sample[SAMPLE_WIDTH-1], cur_sample})
            + $signed({fb_term[SAMPLE_WIDTH-1], fb_term});
    if (fb_sum[SAMPLE_WIDTH] != fb_sum[SAMPLE_WIDTH-1]) begin
      wr_data = fb_sum[SAMPLE_WIDTH] ? {1'b1, {(SAMPLE_WIDTH-1){1'b0}}}
                                     : {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    end else begin
      wr_data = fb_sum[SAMPLE_WIDTH-1:0];
    end
`else
    wr_data = cur_sample;
`endif
  end

  // Ring storage is never reset; the fill counter keeps stale words from reaching the output.
  always_ff @(posedge audio_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      state            <= IDLE;
      step             <= '0;
      wr_ptr           <= '0;
      fill             <= '0;
      busy             <= 1'b0;
      overrun          <= 1'b0;
      sample_valid_out <= 1'b0;
      out_reg          <= '0;
      out_stage        <= '0;
      in_frame         <= '0;
      delay_frame      <= '0;
    end else begin
      state            <= state_next;
      sample_valid_out <= 1'b0;
      if (sample_valid_in && (state != IDLE)) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (sample_valid_in) begin
            in_frame    <= sample_in;
            delay_frame <= delay_in;
            busy        <= 1'b1;
            step        <= '0;
          end
        end
        RUN: begin
          step      <= step + 1'b1;
          out_stage <= out_stage_next;
          if (step == LAST_STEP) begin
            sample_valid_out <= 1'b1;
            out_reg          <= out_stage_next;
          end
        end
        DONE: begin
          wr_ptr <= wr_ptr + 1'b1;
          if (fill != '1) fill <= fill + 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multichannel_delay_line.sv
// tb/tb_multichannel_delay_line.sv - scoreboard bench for multichannel_delay_line
module tb_multichannel_delay_line;

  localparam int N  = 3;
  localparam int SW = 16;
  localparam int DW = 12;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            valid_in = 1'b0;
  logic [N*SW-1:0] samples = '0;
  logic [N*DW-1:0] delays = '0;
  logic            valid_out;
  logic [N*SW-1:0] out_data;
  logic            busy;
  logic            overrun;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  typedef struct {
    logic [N*SW-1:0] data;
    int              due;
  } exp_t;

  exp_t exp_q[$];

  multichannel_delay_line dut (
    .audio_clk       (clk),
    .rst_in          (rst),
    .sample_valid_in (valid_in),
    .sample_in       (samples),
    .delay_in        (delays),
    .sample_valid_out(valid_out),
    .sample_out      (out_data),
    .busy            (busy),
    .overrun         (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [N*SW-1:0] s3(input int a, input int b, input int c);
    logic [SW-1:0] x, y, z;
    x = SW'(a); y = SW'(b); z = SW'(c);
    return {z, y, x};
  endfunction

  function automatic logic [N*DW-1:0] d3(input int a, input int b, input int c);
    logic [DW-1:0] x, y, z;
    x = DW'(a); y = DW'(b); z = DW'(c);
    return {z, y, x};
  endfunction

  task automatic check(input string name, input logic [N*SW-1:0] act, input logic [N*SW-1:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  // Monitor: every output strobe must match the oldest expected frame and its due cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 48'(1), 48'(0));
        end else begin
          e = exp_q.pop_front();
          check("out_frame", out_data, e.data);
          check("out_latency", 48'(cyc), 48'(e.due));
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    valid_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One accepted frame; output expected N+2 cycles after the strobe cycle.
  task automatic send(input logic [N*SW-1:0] s, input logic [N*DW-1:0] d, input logic [N*SW-1:0] e);
    @(negedge clk);
    samples = s;
    delays = d;
    valid_in = 1'b1;
    exp_q.push_back('{e, cyc + N + 2});
    @(negedge clk);
    valid_in = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid_out", 48'(valid_out), 48'(0));
    check("rst_sample_out", out_data, 48'(0));
    check("rst_busy", 48'(busy), 48'(0));
    check("rst_overrun", 48'(overrun), 48'(0));
    rst = 1'b0;

    // Test 1: zero delay passthrough, busy profile
    @(negedge clk);
    samples = s3(100, -200, 300);
    delays = d3(0, 0, 0);
    valid_in = 1'b1;
    exp_q.push_back('{s3(100, -200, 300), cyc + N + 2});
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      valid_in = 1'b0;
      check($sformatf("busy_t%0d", i), 48'(busy), 48'(i <= 5));
    end
    repeat (2) @(negedge clk);

    // Test 2: delays 1/2/5
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      send(s3(k, 1000 + k, -k), d3(1, 2, 5),
           s3(k - 1, (k >= 3) ? 1000 + k - 2 : 0, (k >= 6) ? -(k - 5) : 0));
    end

    // Test 3: maximum delay with pointer wrap
    do_reset();
    for (int k = 1; k <= 5000; k++) begin
      send(s3(k, -k, 7), d3(4095, 0, 0), s3((k >= 4096) ? k - 4095 : 0, -k, 7));
    end

    // Test 4: overrun on busy and on the DONE cycle
    do_reset();
    @(negedge clk);
    samples = s3(7, 8, 9);
    delays = d3(0, 0, 0);
    valid_in = 1'b1;
    exp_q.push_back('{s3(7, 8, 9), cyc + N + 2});
    @(negedge clk); valid_in = 1'b0;
    @(negedge clk); samples = s3(50, 51, 52); valid_in = 1'b1;
    @(negedge clk); valid_in = 1'b0;
    check("overrun_busy", 48'(overrun), 48'(1));
    @(negedge clk);
    @(negedge clk); valid_in = 1'b1;
    @(negedge clk); valid_in = 1'b0;
    check("overrun_done", 48'(overrun), 48'(1));
    repeat (2) @(negedge clk);
    send(s3(1, 2, 3), d3(0, 0, 0), s3(1, 2, 3));
    check("overrun_sticky", 48'(overrun), 48'(1));

    // Test 5: reset mid-frame at step 1
    @(negedge clk);
    samples = s3(11, 12, 13);
    delays = d3(0, 0, 0);
    valid_in = 1'b1;
    @(negedge clk); valid_in = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1;
    check("abort_busy", 48'(busy), 48'(0));
    check("abort_overrun", 48'(overrun), 48'(0));
    check("abort_valid", 48'(valid_out), 48'(0));
    check("abort_out", out_data, 48'(0));
    @(negedge clk); rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      send(s3(20 + k, -20 - k, k), d3(3, 3, 3),
           (k > 3) ? s3(20 + k - 3, -20 - k + 3, k - 3) : s3(0, 0, 0));
    end

`ifdef MULTICHANNEL_DELAY_FEEDBACK_EN
    // Test 6: decaying echo and saturation of the stored value
    do_reset();
    begin
      int fin [7] = '{16000, 0, 0, 0, 0, 0, 0};
      int fout[7] = '{0, 0, 16000, 0, 8000, 0, 4000};
      for (int k = 0; k < 7; k++) send(s3(fin[k], 0, 0), d3(2, 0, 0), s3(fout[k], 0, 0));
    end
    do_reset();
    begin
      int sin [5] = '{30000, 0, 30000, 0, 0};
      int sout[5] = '{0, 0, 30000, 0, 32767};
      for (int k = 0; k < 5; k++) send(s3(sin[k], 0, 0), d3(2, 0, 0), s3(sout[k], 0, 0));
    end
`endif

    repeat (10) @(negedge clk);
    check("queue_drained", 48'(exp_q.size()), 48'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
